// File: rtl/rr_encoder32to5_pkg.sv
// rr_encoder32to5_pkg: shared constants and FSM state encoding for the round-robin encoder
package rr_encoder32to5_pkg;
  localparam int N = 32;
  localparam int W = 5;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/rr_encoder32to5_pick.sv
// rr_pick32: combinational round-robin pick of the first set request at or after ptr
module rr_pick32
  import rr_encoder32to5_pkg::*;
(
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  logic [W-1:0] off;
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  assign found = |req;
  assign index = off + ptr;
  // lowest set bit of the rotated vector is the first requester at or after ptr
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? W'(i) : off;
  end
endmodule

// File: rtl/rr_encoder32to5.sv
// rr_encoder32to5: round-robin 32-to-5 encoder with registered index and valid/ready handshake
module rr_encoder32to5
  import rr_encoder32to5_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic [W-1:0] ptr_q
);
  state_t state_q, state_d;
  logic found;
  logic [W-1:0] pick;
  rr_pick32 u_pick (.req(req), .ptr(ptr_q), .found(found), .index(pick));
  assign valid = state_q == HOLD;
  assign grant = valid ? N'(1) << idx : '0;
  // grant on any request when idle, release on ready when holding
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = found ? HOLD : IDLE;
    else state_d = ready ? IDLE : HOLD;
  end
  // state, held index and rotating priority pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) idx <= pick;
      if (state_q == HOLD && ready) ptr_q <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_encoder32to5.sv
// tb_rr_encoder32to5: scoreboard bench comparing the encoder against a round-robin reference model
module tb_rr_encoder32to5;
  logic clk = 0, reset = 1, ready = 0;
  logic [31:0] req = '0;
  logic valid;
  logic [4:0] idx, ptr_q;
  logic [31:0] grant;
  int tests = 0, fails = 0;
  int q[$];
  int m_ptr = 0, m_idx = 0;
  bit m_valid = 0, m_rst = 0, checking = 0;

  rr_encoder32to5 dut (.clk(clk), .reset(reset), .req(req), .ready(ready),
                       .valid(valid), .idx(idx), .grant(grant), .ptr_q(ptr_q));

  always #5 clk = ~clk;

  function automatic int scan(input logic [31:0] r, input int p);
    for (int k = 0; k < 32; k++) if (r[(p + k) % 32]) return (p + k) % 32;
    return -1;
  endfunction

  task automatic model();
    m_rst = reset;
    if (reset) begin
      q.delete();
      m_valid = 0;
      m_ptr = 0;
      checking = 1;
    end else if (!m_valid) begin
      if (req != 0) begin
        m_idx = scan(req, m_ptr);
        q.push_back(m_idx);
        m_valid = 1;
      end
    end else if (ready) begin
      m_valid = 0;
      m_ptr = (m_idx + 1) % 32;
    end
  endtask

  task automatic cyc(input logic [31:0] r, input logic rd, input logic rs);
    @(posedge clk);
    model();
    #1;
    req = r;
    ready = rd;
    reset = rs;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("valid", int'(valid), int'(m_valid));
      chk("ptr_q", int'(ptr_q), m_ptr);
      if (m_rst) chk("reset_idx", int'(idx), 0);
      if (!valid) chk("grant_idle", int'(grant), 0);
      else if (q.size() == 0) chk("unexpected_grant", int'(idx), -1);
      else begin
        chk("idx", int'(idx), q[0]);
        chk("grant", int'(grant), int'(32'h1 << q[0]));
        if (ready && !reset) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] r;
    repeat (2) cyc(0, 0, 1);
    repeat (5) cyc(0, 1, 0);
    repeat (12) cyc(32'h14, 1, 0);
    cyc(0, 0, 1);
    repeat (70) cyc(32'hFFFF_FFFF, 1, 0);
    cyc(0, 0, 1);
    repeat (2) cyc(32'h1, 1, 0);
    repeat (4) cyc(32'h8000_0001, 1, 0);
    cyc(0, 0, 1);
    cyc(32'h80, 0, 0);
    repeat (4) cyc(32'h100, 0, 0);
    repeat (4) cyc(32'h100, 1, 0);
    cyc(0, 0, 1);
    cyc(32'h1000, 0, 0);
    repeat (2) cyc(32'h1000, 0, 0);
    cyc(32'h1000, 0, 1);
    repeat (4) cyc(32'h1000, 1, 0);
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: r = 32'h1 << $urandom_range(0, 31);
        1: r = $urandom & $urandom & $urandom;
        2: r = $urandom;
        default: r = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'hFFFF_FFFF;
      endcase
      cyc(r, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end
    repeat (4) cyc(0, 1, 0);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_encoder32to5.md
Name: rr_encoder32to5

Overview:
- Round-robin encoder that converts 32 request lines into a registered 5-bit index with a valid/ready handshake. It is the inverse of the 5-to-32 select decoder.
- Used wherever one-of-N requesters must be turned back into a binary register or port number, e.g. pending-writeback or interrupt source selection.
- Priority rotates after each accepted grant, so no requester is starved.

Parameters:
- N, 32, number of request lines (fixed at 32 for this release)
- W, 5, index width, always log2(N)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  32  level-sensitive request vector; bit i = requester i
- ready  input  1  consumer accepts the presented index this cycle
- valid  output  1  idx/grant hold a registered grant
- idx  output  5  binary index of the granted requester
- grant  output  32  one-hot decode of idx, qualified by valid (all zero when valid=0)
- ptr_q  output  5  current highest-priority position (debug/observability)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: valid=0, idx=0, grant=0, ptr_q=0, state=IDLE. Reset asserted mid-HOLD drops the pending grant with no acceptance. ptr_q returns to 0.
- States:
  - IDLE: no grant held.
  - HOLD: valid=1, waiting for ready.
- IDLE:
  - If req != 0: select the first set bit scanning ptr_q, ptr_q+1, ..., 31, 0, ..., ptr_q-1 (wrap modulo 32).
  - Register that bit's index into idx, set valid=1, go to HOLD.
  - Latency is one cycle from req sampled to valid high.
  - If req == 0: stay in IDLE, valid=0.
- HOLD:
  - idx, grant and valid stay stable regardless of req changes; a requester dropping its line does not revoke the grant.
  - On ready=1: handshake completes that edge, ptr_q <= idx+1 (5-bit wrap, so 31 -> 0), valid <= 0, go to IDLE.
  - On ready=0: remain in HOLD.
- Throughput: at most one grant per two cycles. After acceptance, valid is low for one cycle (the IDLE scan cycle) before the next grant.
- ready is ignored in IDLE; it has no effect on ptr_q.
- Single requester: the same index is re-granted every two cycles while it keeps req high.
- All 32 requesting: grants cycle 0, 1, 2, ..., 31, 0 starting from ptr_q=0.
- Arithmetic: all index math is 5-bit unsigned with natural wrap. No X may propagate to idx/grant when req=0.
- grant is derived combinationally from registered idx and valid (no extra latency). Exactly one bit is set when valid=1.

Decomposition:
- Shared package/header: constants N=32, W=5, state encodings IDLE=1'b0, HOLD=1'b1.
- One natural sub-module: rr_pick32, purely combinational.
  - Inputs: req, ptr.
  - Outputs: found, index.
  - Implemented as rotate-by-ptr, fixed lowest-set-bit priority encode, then add ptr back (mod 32).
- The top level holds the FSM, ptr_q and idx registers, and the one-hot grant decode.

Test Plan:
- Reset then req=0 for 5 cycles -> valid=0, idx=0, grant=0, ptr_q=0 throughout.
- req=32'h0000_0014, ready=1 held -> grants idx=2 then idx=4 then idx=2, each with valid high one cycle in two; grant=32'h4, 32'h10, 32'h4; ptr_q goes 3, 5, 3.
- req=32'hFFFF_FFFF, ready=1 -> idx sequence 0, 1, ..., 31, 0. On the 31 acceptance ptr_q wraps to 0.
- req=32'h8000_0001 with ptr_q=1 -> idx=31. After acceptance ptr_q=0 and the next grant is idx=0.
- Grant idx=7 pending with ready=0 for 4 cycles while req changes to 32'h0000_0100 -> idx stays 7, grant=32'h80, valid=1. On ready=1, ptr_q=8, and the next grant is idx=8.
- reset asserted while valid=1 (idx=12) -> next edge valid=0, idx=0, ptr_q=0. Then req=32'h1000 -> idx=12 one cycle later.
